// File: rtl/jtframe_pocket_prog_if.sv
// Download-to-SDRAM programming bus: ioctl byte stream in, SDRAM write port out.
// The master side is the programmer; the slave side is the loader/SDRAM environment.
interface jtframe_pocket_prog_if;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        byte_rdy;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_rdy;
  logic        err_timeout;
  logic        err_ovf;

  modport master (
    input  downloading, ioctl_addr, ioctl_dout, ioctl_wr, prog_rdy,
    output byte_rdy, prog_addr, prog_data, prog_mask, prog_ba, prog_we,
           err_timeout, err_ovf
  );

  modport slave (
    output downloading, ioctl_addr, ioctl_dout, ioctl_wr, prog_rdy,
    input  byte_rdy, prog_addr, prog_data, prog_mask, prog_ba, prog_we,
           err_timeout, err_ovf
  );
endinterface

// File: rtl/jtframe_pocket_prog.sv
// Turns the ROM download byte stream into SDRAM word writes, skipping a header
// and splitting the payload across up to four banks.
module jtframe_pocket_prog #(
  parameter int          HEADER    = 0,
  parameter logic [24:0] BA1_START = 25'h1F_FFFF,
  parameter logic [24:0] BA2_START = 25'h1F_FFFF,
  parameter logic [24:0] BA3_START = 25'h1F_FFFF,
  parameter int          TIMEOUT   = 1023
) (
  input  logic                   clk_rom,
  input  logic                   rst,
  jtframe_pocket_prog_if.master  bus
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t      state_q, state_d;
  logic        prog_we_q, prog_we_d;
  logic        byte_rdy_q, byte_rdy_d;
  logic [21:0] prog_addr_q, prog_addr_d;
  logic [15:0] prog_data_q, prog_data_d;
  logic [1:0]  prog_mask_q, prog_mask_d;
  logic [1:0]  prog_ba_q, prog_ba_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        err_to_q, err_to_d;
  logic        err_ovf_q, err_ovf_d;
  logic        dl_q;

  logic [24:0] eff, base, off;
  logic [1:0]  ba_sel;
  logic        dl_rise;

  always_comb begin
    eff = bus.ioctl_addr - 25'(HEADER);
    if (eff >= BA3_START) begin
      ba_sel = 2'd3; base = BA3_START;
    end else if (eff >= BA2_START) begin
      ba_sel = 2'd2; base = BA2_START;
    end else if (eff >= BA1_START) begin
      ba_sel = 2'd1; base = BA1_START;
    end else begin
      ba_sel = 2'd0; base = 25'd0;
    end
    off     = eff - base;
    dl_rise = bus.downloading & ~dl_q;

    state_d     = state_q;
    prog_we_d   = prog_we_q;
    byte_rdy_d  = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prog_ba_d   = prog_ba_q;
    timer_d     = timer_q;
    err_to_d    = err_to_q;
    err_ovf_d   = err_ovf_q;

    if (dl_rise) begin
      err_to_d  = 1'b0;
      err_ovf_d = 1'b0;
    end

    // Dropping downloading aborts everything silently, no byte_rdy.
    if (!bus.downloading) begin
      state_d   = IDLE;
      prog_we_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ioctl_wr) begin
            if (bus.ioctl_addr < 25'(HEADER)) begin
              state_d    = ACK;
              byte_rdy_d = 1'b1;
            end else begin
              state_d     = WRITE;
              prog_we_d   = 1'b1;
              timer_d     = '0;
              prog_addr_d = off[22:1];
              prog_data_d = {bus.ioctl_dout, bus.ioctl_dout};
              prog_mask_d = off[0] ? 2'b01 : 2'b10;
              prog_ba_d   = ba_sel;
            end
          end
        end
        WRITE: begin
          if (bus.ioctl_wr) err_ovf_d = 1'b1;
          // An acknowledge on the final timeout cycle still wins.
          if (bus.prog_rdy) begin
            state_d    = ACK;
            prog_we_d  = 1'b0;
            byte_rdy_d = 1'b1;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d    = ACK;
            prog_we_d  = 1'b0;
            byte_rdy_d = 1'b1;
            err_to_d   = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ACK: begin
          if (bus.ioctl_wr) err_ovf_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state_q     <= IDLE;
      prog_we_q   <= 1'b0;
      byte_rdy_q  <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= 2'b11;
      prog_ba_q   <= '0;
      timer_q     <= '0;
      err_to_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
      dl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_we_q   <= prog_we_d;
      byte_rdy_q  <= byte_rdy_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_ba_q   <= prog_ba_d;
      timer_q     <= timer_d;
      err_to_q    <= err_to_d;
      err_ovf_q   <= err_ovf_d;
      dl_q        <= bus.downloading;
    end
  end

  assign bus.prog_we     = prog_we_q;
  assign bus.byte_rdy    = byte_rdy_q;
  assign bus.prog_addr   = prog_addr_q;
  assign bus.prog_data   = prog_data_q;
  assign bus.prog_mask   = prog_mask_q;
  assign bus.prog_ba     = prog_ba_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_ovf     = err_ovf_q;
endmodule
